// File: rtl/lcd_timing_detector.sv
// Measures line/frame geometry of an hsync/vsync/de stream and declares lock
// once consecutive frames measure identically; outputs are registered snapshots.
module lcd_timing_detector #(
  parameter int C_WIDTH       = 12,
  parameter int C_LOCK_FRAMES = 2
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iHsync,
  input  logic               iVsync,
  input  logic               iDe,
  output logic [C_WIDTH-1:0] oHTotal,
  output logic [C_WIDTH-1:0] oHActive,
  output logic [C_WIDTH-1:0] oVTotal,
  output logic [C_WIDTH-1:0] oVActive,
  output logic               oFrameDone,
  output logic               oLocked
);

  localparam logic [C_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [3:0]         LOCK_N  = 4'(C_LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_TRACK,
    ST_LOCKED
  } state_t;

  function automatic logic [C_WIDTH-1:0] ext1(input logic b);
    return {{(C_WIDTH-1){1'b0}}, b};
  endfunction

  function automatic logic [C_WIDTH-1:0] sat_inc(input logic [C_WIDTH-1:0] v, input logic inc);
    if (v == CNT_MAX) return CNT_MAX;
    return v + ext1(inc);
  endfunction

  logic               hs_prev_q, vs_prev_q;
  logic [C_WIDTH-1:0] h_cnt_q, h_cnt_d;
  logic [C_WIDTH-1:0] de_cnt_q, de_cnt_d;
  logic [C_WIDTH-1:0] line_total_q, line_total_d;
  logic [C_WIDTH-1:0] h_act_max_q, h_act_max_d;
  logic [C_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic [C_WIDTH-1:0] va_cnt_q, va_cnt_d;
  logic               line_de_q, line_de_d;

  logic [C_WIDTH-1:0] h_total_q, h_active_q, v_total_q, v_active_q;
  logic               frame_done_q, locked_q;
  logic [3:0]         match_q;
  state_t             state_q;

  logic               h_rise, v_rise, de_first, wdog, same;
  logic [C_WIDTH-1:0] fold_de, snap_ht, snap_ha;
  logic [3:0]         match_inc;

  assign h_rise    = iHsync & ~hs_prev_q;
  assign v_rise    = iVsync & ~vs_prev_q;
  assign de_first  = iDe & (h_rise | ~line_de_q);
  // A line ending on the exact saturation cycle is still a live line.
  assign wdog      = (h_cnt_q == CNT_MAX) & ~h_rise;
  assign match_inc = match_q + 4'd1;

  assign fold_de = h_rise ? de_cnt_q : '0;
  assign snap_ht = h_rise ? h_cnt_q : line_total_q;
  assign snap_ha = (fold_de > h_act_max_q) ? fold_de : h_act_max_q;
  assign same    = (snap_ht == h_total_q) && (snap_ha == h_active_q) &&
                   (line_cnt_q == v_total_q) && (va_cnt_q == v_active_q);

  always_comb begin
    h_cnt_d      = h_rise ? ext1(1'b1) : sat_inc(h_cnt_q, 1'b1);
    de_cnt_d     = h_rise ? ext1(iDe) : sat_inc(de_cnt_q, iDe);
    line_total_d = h_rise ? h_cnt_q : line_total_q;
    line_cnt_d   = v_rise ? ext1(h_rise) : sat_inc(line_cnt_q, h_rise);
    va_cnt_d     = v_rise ? ext1(de_first) : sat_inc(va_cnt_q, de_first);
    line_de_d    = h_rise ? iDe : (line_de_q | iDe);
    h_act_max_d  = h_act_max_q;
    // On a coincident vRise the finished line goes to the snapshot only.
    if (v_rise)
      h_act_max_d = '0;
    else if (h_rise && (de_cnt_q > h_act_max_q))
      h_act_max_d = de_cnt_q;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      hs_prev_q    <= 1'b1;
      vs_prev_q    <= 1'b1;
      h_cnt_q      <= '0;
      de_cnt_q     <= '0;
      line_total_q <= '0;
      h_act_max_q  <= '0;
      line_cnt_q   <= '0;
      va_cnt_q     <= '0;
      line_de_q    <= 1'b0;
    end else begin
      hs_prev_q    <= iHsync;
      vs_prev_q    <= iVsync;
      h_cnt_q      <= h_cnt_d;
      de_cnt_q     <= de_cnt_d;
      line_total_q <= line_total_d;
      h_act_max_q  <= h_act_max_d;
      line_cnt_q   <= line_cnt_d;
      va_cnt_q     <= va_cnt_d;
      line_de_q    <= line_de_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q      <= ST_IDLE;
      match_q      <= '0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      h_total_q    <= '0;
      h_active_q   <= '0;
      v_total_q    <= '0;
      v_active_q   <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (wdog) begin
        state_q  <= ST_IDLE;
        locked_q <= 1'b0;
        match_q  <= '0;
      end else if (v_rise) begin
        if (state_q != ST_IDLE) begin
          h_total_q    <= snap_ht;
          h_active_q   <= snap_ha;
          v_total_q    <= line_cnt_q;
          v_active_q   <= va_cnt_q;
          frame_done_q <= 1'b1;
        end
        case (state_q)
          ST_IDLE: state_q <= ST_FIRST;
          ST_FIRST: begin
            state_q <= ST_TRACK;
            match_q <= '0;
          end
          ST_TRACK: begin
            if (!same) begin
              match_q <= '0;
            end else begin
              match_q <= match_inc;
              if (match_inc == LOCK_N) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end
          end
          ST_LOCKED: begin
            if (!same) begin
              state_q  <= ST_TRACK;
              locked_q <= 1'b0;
              match_q  <= '0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign oHTotal    = h_total_q;
  assign oHActive   = h_active_q;
  assign oVTotal    = v_total_q;
  assign oVActive   = v_active_q;
  assign oFrameDone = frame_done_q;
  assign oLocked    = locked_q;

endmodule

// File: tb/tb_lcd_timing_detector.sv
// Directed bench: 100-clock lines, 10-clock hsync, 80 DE clocks on lines 3..18.
module tb_lcd_timing_detector;

  logic        iClk = 1'b0;
  logic        iRst, iHsync, iVsync, iDe;
  logic [11:0] oHTotal, oHActive, oVTotal, oVActive;
  logic        oFrameDone, oLocked;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulse;
  int p_ht, p_ha, p_vt, p_va, p_lk;

  always #5 iClk = ~iClk;

  lcd_timing_detector #(.C_WIDTH(12), .C_LOCK_FRAMES(2)) dut (
    .iClk(iClk), .iRst(iRst), .iHsync(iHsync), .iVsync(iVsync), .iDe(iDe),
    .oHTotal(oHTotal), .oHActive(oHActive), .oVTotal(oVTotal), .oVActive(oVActive),
    .oFrameDone(oFrameDone), .oLocked(oLocked)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
    if (oFrameDone) begin
      n_pulse++;
      p_ht = int'(oHTotal);
      p_ha = int'(oHActive);
      p_vt = int'(oVTotal);
      p_va = int'(oVActive);
      p_lk = int'(oLocked);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ht"}, int'(oHTotal), 0);
    check({tag, "_ha"}, int'(oHActive), 0);
    check({tag, "_vt"}, int'(oVTotal), 0);
    check({tag, "_va"}, int'(oVActive), 0);
    check({tag, "_done"}, int'(oFrameDone), 0);
    check({tag, "_lock"}, int'(oLocked), 0);
  endtask

  // vsync is high for 300 clocks starting voff clocks into the frame.
  task automatic run_frame(input int lines, input bit de_on, input int voff, input int rst_line);
    n_pulse = 0;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < 100; p++) begin
        int idx;
        idx    = l * 100 + p;
        iHsync = (p < 10);
        iVsync = (idx >= voff) && (idx < voff + 300);
        iDe    = de_on && (l >= 3) && (l <= 18) && (p >= 10) && (p < 90);
        iRst   = (l == rst_line) && (p == 40);
        tick();
        if (iRst) check_zero("mid_rst");
      end
    end
    iRst = 1'b0;
  endtask

  task automatic check_pulse(input string tag, input int ht, input int ha, input int vt,
                             input int va, input int lk);
    check({tag, "_npulse"}, n_pulse, 1);
    check({tag, "_ht"}, p_ht, ht);
    check({tag, "_ha"}, p_ha, ha);
    check({tag, "_vt"}, p_vt, vt);
    check({tag, "_va"}, p_va, va);
    check({tag, "_lock"}, p_lk, lk);
  endtask

  initial begin
    n_pulse = 0;
    {p_ht, p_ha, p_vt, p_va, p_lk} = '0;
    iRst = 1'b1; iHsync = 1'b0; iVsync = 1'b0; iDe = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    iRst = 1'b0;
    repeat (2) tick();

    // Stable stream with coincident hsync/vsync edges; lock on 4th vRise.
    run_frame(20, 1'b1, 0, -1);
    check("f1_npulse", n_pulse, 0);
    run_frame(20, 1'b1, 0, -1);
    check_pulse("f2", 100, 80, 20, 16, 0);
    run_frame(20, 1'b1, 0, -1);
    check_pulse("f3", 100, 80, 20, 16, 0);
    run_frame(20, 1'b1, 0, -1);
    check_pulse("f4", 100, 80, 20, 16, 1);

    // One 21-line frame drops lock; three more pulses to regain it.
    run_frame(21, 1'b1, 0, -1);
    check_pulse("f5", 100, 80, 20, 16, 1);
    run_frame(20, 1'b1, 0, -1);
    check_pulse("f6", 100, 80, 21, 16, 0);
    run_frame(20, 1'b1, 0, -1);
    check_pulse("f7", 100, 80, 20, 16, 0);
    run_frame(20, 1'b1, 0, -1);
    check_pulse("f8", 100, 80, 20, 16, 0);
    run_frame(20, 1'b1, 0, -1);
    check_pulse("f9", 100, 80, 20, 16, 1);

    // Frame with DE stuck low.
    run_frame(20, 1'b0, 0, -1);
    check_pulse("f10", 100, 80, 20, 16, 1);
    run_frame(20, 1'b1, 0, -1);
    check_pulse("f11_nodE", 100, 0, 20, 0, 0);
    run_frame(20, 1'b1, 0, -1);
    run_frame(20, 1'b1, 0, -1);
    run_frame(20, 1'b1, 0, -1);
    check_pulse("f14", 100, 80, 20, 16, 1);

    // Watchdog: last hRise was 99 clocks ago; trips 4095 clocks after it.
    iHsync = 1'b0; iVsync = 1'b0; iDe = 1'b0;
    repeat (3995) tick();
    check("wd_before", int'(oLocked), 1);
    tick();
    check("wd_after", int'(oLocked), 0);
    check("wd_ht", int'(oHTotal), 100);
    check("wd_ha", int'(oHActive), 80);
    check("wd_vt", int'(oVTotal), 20);
    check("wd_va", int'(oVActive), 16);

    // Restart from IDLE, then reset mid-frame during line 7.
    run_frame(20, 1'b1, 0, -1);
    check("f16_npulse", n_pulse, 0);
    run_frame(20, 1'b1, 0, 7);
    check_pulse("f17", 100, 80, 20, 16, 0);
    run_frame(20, 1'b1, 0, -1);
    check("f18_npulse", n_pulse, 0);
    run_frame(20, 1'b1, 0, -1);
    check_pulse("f19", 100, 80, 20, 16, 0);

    // vsync moved 50 clocks into line 0: hTotal comes from the captured line period.
    run_frame(20, 1'b1, 50, -1);
    check_pulse("f20_shift", 100, 80, 21, 16, 0);
    run_frame(20, 1'b1, 50, -1);
    check_pulse("f21_shift", 100, 80, 20, 16, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
